// File: rtl/soc_b3_wb_rr_pkg.sv
// Shared types and helpers for the soc_b3_wb_rr Wishbone B3 shared bus.
package soc_b3_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Callers zero-extend to this width so one helper serves any ADDR_WIDTH up to 64.
    localparam int MAX_AW = 64;

    function automatic logic addr_hit(input logic [MAX_AW-1:0] adr,
                                      input logic [MAX_AW-1:0] base,
                                      input logic [MAX_AW-1:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/soc_b3_wb_rr_if.sv
// Bus bundle for soc_b3_wb_rr: master-facing request/response and slave-facing broadcast/response.
// Modport master is the interconnect (it masters the slave side); modport slave is the endpoint agents.
interface soc_b3_wb_rr_if #(
    parameter int MASTERS    = 2,
    parameter int SLAVES     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [MASTERS-1:0][ADDR_WIDTH-1:0] m_adr_i;
    logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dat_i;
    logic [MASTERS-1:0][SEL_WIDTH-1:0]  m_sel_i;
    logic [MASTERS-1:0]                 m_cyc_i;
    logic [MASTERS-1:0]                 m_stb_i;
    logic [MASTERS-1:0]                 m_we_i;
    logic [MASTERS-1:0][2:0]            m_cti_i;
    logic [MASTERS-1:0][1:0]            m_bte_i;
    logic [MASTERS-1:0][DATA_WIDTH-1:0] m_dat_o;
    logic [MASTERS-1:0]                 m_ack_o;
    logic [MASTERS-1:0]                 m_err_o;
    logic [MASTERS-1:0]                 m_rty_o;

    logic [SLAVES-1:0][ADDR_WIDTH-1:0]  s_adr_o;
    logic [SLAVES-1:0][DATA_WIDTH-1:0]  s_dat_o;
    logic [SLAVES-1:0][SEL_WIDTH-1:0]   s_sel_o;
    logic [SLAVES-1:0]                  s_we_o;
    logic [SLAVES-1:0][2:0]             s_cti_o;
    logic [SLAVES-1:0][1:0]             s_bte_o;
    logic [SLAVES-1:0]                  s_cyc_o;
    logic [SLAVES-1:0]                  s_stb_o;
    logic [SLAVES-1:0][DATA_WIDTH-1:0]  s_dat_i;
    logic [SLAVES-1:0]                  s_ack_i;
    logic [SLAVES-1:0]                  s_err_i;
    logic [SLAVES-1:0]                  s_rty_i;

    modport master (
        input  m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cti_i, m_bte_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

    modport slave (
        output m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, m_cti_i, m_bte_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i
    );

endinterface

// File: rtl/soc_b3_wb_rr_arb.sv
// soc_rr_arb_wb: round-robin pick of the first requester at or after the pointer (one-hot + index).
module soc_rr_arb_wb #(
    parameter int MASTERS = 2,
    parameter int IDX_W   = 1
) (
    input  logic [MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [MASTERS-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    logic w_found;
    int   w_k;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 0; i < MASTERS; i++) begin
            // Wrap without a modulo operator so MASTERS need not be a power of two.
            w_k = int'(i_ptr) + i;
            if (w_k >= MASTERS) begin
                w_k = w_k - MASTERS;
            end
            if (!w_found && i_req[w_k[IDX_W-1:0]]) begin
                w_found                 = 1'b1;
                o_gnt[w_k[IDX_W-1:0]]   = 1'b1;
                o_idx                   = w_k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/soc_b3_wb_rr.sv
// Shared Wishbone B3 bus: N masters, M base/mask-decoded slaves, round-robin grant, write snoop, bus hold.
// Optional watchdog enabled by defining SOC_B3_WB_TIMEOUT_EN.
module soc_b3_wb_rr
    import soc_b3_wb_pkg::*;
#(
    parameter int MASTERS    = 2,
    parameter int SLAVES     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_BASE = '0,
    parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_MASK = '0,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    soc_b3_wb_rr_if.master          bus,
    input  logic                    bus_hold_i,
    output logic                    bus_hold_ack_o,
    output logic [ADDR_WIDTH-1:0]   snoop_adr_o,
    output logic [DATA_WIDTH-1:0]   snoop_dat_o,
    output logic [DATA_WIDTH/8-1:0] snoop_sel_o,
    output logic                    snoop_en_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int MIDX_W    = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int SIDX_W    = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    state_e                r_state, w_next;
    logic [MIDX_W-1:0]     r_gidx, w_gidx_nxt;
    logic [MIDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic [MASTERS-1:0]    w_arb_gnt;
    logic [MIDX_W-1:0]     w_arb_idx;

    logic                  w_gcyc, w_gstb, w_gwe;
    logic [ADDR_WIDTH-1:0] w_gadr;
    logic [DATA_WIDTH-1:0] w_gdat;
    logic [SEL_WIDTH-1:0]  w_gsel;
    logic [2:0]            w_gcti;
    logic [1:0]            w_gbte;

    logic                  w_active, w_hit, w_route, w_blk, w_tmo;
    logic [SIDX_W-1:0]     w_sidx;
    logic                  w_s_ack, w_s_err, w_s_rty, w_miss_err;

    logic                  r_snoop_en;
    logic [ADDR_WIDTH-1:0] r_snoop_adr;
    logic [DATA_WIDTH-1:0] r_snoop_dat;
    logic [SEL_WIDTH-1:0]  r_snoop_sel;

    soc_rr_arb_wb #(
        .MASTERS (MASTERS),
        .IDX_W   (MIDX_W)
    ) u_arb (
        .i_req   (bus.m_cyc_i),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx)
    );

    assign w_gcyc   = bus.m_cyc_i[r_gidx];
    assign w_gstb   = bus.m_stb_i[r_gidx];
    assign w_gwe    = bus.m_we_i[r_gidx];
    assign w_gadr   = bus.m_adr_i[r_gidx];
    assign w_gdat   = bus.m_dat_i[r_gidx];
    assign w_gsel   = bus.m_sel_i[r_gidx];
    assign w_gcti   = bus.m_cti_i[r_gidx];
    assign w_gbte   = bus.m_bte_i[r_gidx];

    // The release cycle (granted cyc already low) is not active, so it never strobes.
    assign w_active = (r_state == BUSY) && w_gcyc;

    // Descending scan so the lowest matching slave index wins.
    always_comb begin
        w_hit  = 1'b0;
        w_sidx = '0;
        for (int s = SLAVES - 1; s >= 0; s--) begin
            if (addr_hit(MAX_AW'(w_gadr), MAX_AW'(S_BASE[s]), MAX_AW'(S_MASK[s]))) begin
                w_hit  = 1'b1;
                w_sidx = SIDX_W'(s);
            end
        end
    end

    assign w_route    = w_active && w_hit && !w_blk;
    assign w_s_ack    = w_route && w_gstb && bus.s_ack_i[w_sidx];
    assign w_s_err    = w_route && w_gstb && bus.s_err_i[w_sidx];
    assign w_s_rty    = w_route && w_gstb && bus.s_rty_i[w_sidx];
    assign w_miss_err = w_active && !w_hit && w_gstb && !w_blk;

`ifdef SOC_B3_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_blk;
    logic             w_term;

    assign w_term = w_s_ack || w_s_err || w_s_rty || w_miss_err;
    assign w_blk  = r_tmo_blk;
    assign w_tmo  = w_active && w_gstb && !r_tmo_blk && !w_term &&
                    (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    // After firing, the slave side stays dark until the master gives up the cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tmo_cnt <= '0;
            r_tmo_blk <= 1'b0;
        end else if (!w_active) begin
            r_tmo_cnt <= '0;
            r_tmo_blk <= 1'b0;
        end else begin
            if (w_tmo) begin
                r_tmo_blk <= 1'b1;
            end
            if (w_term) begin
                r_tmo_cnt <= '0;
            end else if (w_gstb && !r_tmo_blk) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end
`else
    assign w_blk = 1'b0;
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.s_we_o  = '0;
        bus.s_cti_o = '0;
        bus.s_bte_o = '0;
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        bus.m_dat_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_rty_o = '0;
        if (w_active) begin
            for (int s = 0; s < SLAVES; s++) begin
                bus.s_adr_o[s] = w_gadr;
                bus.s_dat_o[s] = w_gdat;
                bus.s_sel_o[s] = w_gsel;
                bus.s_we_o[s]  = w_gwe;
                bus.s_cti_o[s] = w_gcti;
                bus.s_bte_o[s] = w_gbte;
            end
        end
        if (w_route) begin
            bus.s_cyc_o[w_sidx]  = 1'b1;
            bus.s_stb_o[w_sidx]  = w_gstb;
            bus.m_dat_o[r_gidx]  = bus.s_dat_i[w_sidx];
        end
        bus.m_ack_o[r_gidx] = w_s_ack;
        bus.m_err_o[r_gidx] = w_s_err || w_miss_err || w_tmo;
        bus.m_rty_o[r_gidx] = w_s_rty;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A hold request raised mid-cycle is honoured from IDLE, after the granted cycle ends.
    always_comb begin
        w_next     = r_state;
        w_gidx_nxt = r_gidx;
        w_ptr_nxt  = r_ptr;
        case (r_state)
            IDLE: begin
                if (bus_hold_i) begin
                    w_next = HOLD;
                end else if (|w_arb_gnt) begin
                    w_next     = BUSY;
                    w_gidx_nxt = w_arb_idx;
                end
            end
            BUSY: begin
                if (!w_gcyc) begin
                    w_next    = IDLE;
                    w_ptr_nxt = (r_gidx == MIDX_W'(MASTERS - 1)) ? '0 : r_gidx + 1'b1;
                end
            end
            HOLD: begin
                if (!bus_hold_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_snoop_en  <= 1'b0;
            r_snoop_adr <= '0;
            r_snoop_dat <= '0;
            r_snoop_sel <= '0;
        end else begin
            r_snoop_en <= w_s_ack && w_gwe;
            if (w_s_ack && w_gwe) begin
                r_snoop_adr <= w_gadr;
                r_snoop_dat <= w_gdat;
                r_snoop_sel <= w_gsel;
            end
        end
    end

    assign snoop_en_o     = r_snoop_en;
    assign snoop_adr_o    = r_snoop_adr;
    assign snoop_dat_o    = r_snoop_dat;
    assign snoop_sel_o    = r_snoop_sel;
    assign bus_hold_ack_o = (r_state == HOLD);

endmodule

// File: tb/tb_soc_b3_wb_rr.sv
// Directed bench for soc_b3_wb_rr: two masters, slave0 at 0x0xxx_xxxx, slave1 at 0x1xxx_xxxx.
// Watchdog cases follow SOC_B3_WB_TIMEOUT_EN.
module tb_soc_b3_wb_rr;
    import soc_b3_wb_pkg::*;

    localparam int MASTERS = 2;
    localparam int SLAVES  = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SW      = DW / 8;
    localparam int TMO     = 8;
    localparam logic [SLAVES-1:0][AW-1:0] BASE = {32'h1000_0000, 32'h0000_0000};
    localparam logic [SLAVES-1:0][AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000};

    logic              clk_i  = 1'b0;
    logic              rst_ni = 1'b0;
    logic              bus_hold_i;
    logic              bus_hold_ack_o;
    logic [AW-1:0]     snoop_adr_o;
    logic [DW-1:0]     snoop_dat_o;
    logic [SW-1:0]     snoop_sel_o;
    logic              snoop_en_o;
    logic [SLAVES-1:0] silent;
    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 clk_i = ~clk_i;

    soc_b3_wb_rr_if #(.MASTERS(MASTERS), .SLAVES(SLAVES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    soc_b3_wb_rr #(
        .MASTERS(MASTERS), .SLAVES(SLAVES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .S_BASE(BASE), .S_MASK(MASK), .TIMEOUT(TMO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bus            (bus_if),
        .bus_hold_i     (bus_hold_i),
        .bus_hold_ack_o (bus_hold_ack_o),
        .snoop_adr_o    (snoop_adr_o),
        .snoop_dat_o    (snoop_dat_o),
        .snoop_sel_o    (snoop_sel_o),
        .snoop_en_o     (snoop_en_o)
    );

    // Zero-wait slaves; read data = address ^ (0xA5A5_0000 | slave index).
    always_comb begin
        bus_if.s_ack_i = '0;
        bus_if.s_err_i = '0;
        bus_if.s_rty_i = '0;
        bus_if.s_dat_i = '0;
        for (int s = 0; s < SLAVES; s++) begin
            bus_if.s_ack_i[s] = bus_if.s_cyc_o[s] & bus_if.s_stb_o[s] & ~silent[s];
            bus_if.s_dat_i[s] = bus_if.s_adr_o[s] ^ (32'hA5A5_0000 | 32'(s));
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic req(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel, input logic [2:0] cti);
        bus_if.m_cyc_i[m] = cyc;
        bus_if.m_stb_i[m] = stb;
        bus_if.m_we_i[m]  = we;
        bus_if.m_adr_i[m] = adr;
        bus_if.m_dat_i[m] = dat;
        bus_if.m_sel_i[m] = sel;
        bus_if.m_cti_i[m] = cti;
        bus_if.m_bte_i[m] = BTE_LINEAR;
    endtask

    task automatic drop(input int m);
        req(m, 1'b0, 1'b0, 1'b0, '0, '0, '0, CTI_CLASSIC);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_hold_i = 1'b0;
        silent     = '0;
        drop(0);
        drop(1);
        // Reset, with M0 already requesting
        req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, '0, '0, CTI_CLASSIC);
        step();
        step();
        settle();
        check("rst_scyc", bus_if.s_cyc_o, 2'b00);
        check("rst_mack", bus_if.m_ack_o, 2'b00);
        check("rst_hold_ack", bus_hold_ack_o, 1'b0);
        check("rst_snoop_en", snoop_en_o, 1'b0);

        // Simultaneous request, rr pointer 0 -> M0 first, then M1
        rst_ni = 1'b1;
        req(1, 1'b1, 1'b1, 1'b0, 32'h1000_0000, '0, '0, CTI_CLASSIC);
        settle();
        check("t1_arb_lat", bus_if.s_cyc_o, 2'b00);
        step();
        settle();
        check("t1_m0_scyc", bus_if.s_cyc_o, 2'b01);
        check("t1_m0_ack", bus_if.m_ack_o, 2'b01);
        check("t1_m0_dat", bus_if.m_dat_o[0], 32'hA5A5_0040);
        check("t1_m1_dat", bus_if.m_dat_o[1], 32'h0);
        step();
        drop(0);
        settle();
        check("t1_release_scyc", bus_if.s_cyc_o, 2'b00);
        step();
        settle();
        check("t1_idle_scyc", bus_if.s_cyc_o, 2'b00);
        step();
        settle();
        check("t1_m1_scyc", bus_if.s_cyc_o, 2'b10);
        check("t1_m1_ack", bus_if.m_ack_o, 2'b10);
        check("t1_m1_dat", bus_if.m_dat_o[1], 32'hB5A5_0001);
        step();
        drop(1);
        step();

        // M0 4-beat incrementing burst to slave 1 while M1 waits
        req(0, 1'b1, 1'b1, 1'b0, 32'h1000_0100, '0, '0, CTI_INCR);
        req(1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, '0, '0, CTI_CLASSIC);
        step();
        for (int i = 0; i < 4; i++) begin
            req(0, 1'b1, 1'b1, 1'b0, 32'h1000_0100 + 32'(4 * i), '0, '0,
                (i == 3) ? CTI_EOB : CTI_INCR);
            settle();
            check("t2_burst_stb", bus_if.s_stb_o, 2'b10);
            check("t2_burst_ack", bus_if.m_ack_o, 2'b01);
            check("t2_burst_dat", bus_if.m_dat_o[0], (32'h1000_0100 + 32'(4 * i)) ^ 32'hA5A5_0001);
            step();
        end
        drop(0);
        settle();
        check("t2_release_ack", bus_if.m_ack_o, 2'b00);
        check("t2_release_scyc", bus_if.s_cyc_o, 2'b00);
        step();
        step();
        settle();
        check("t2_m1_scyc", bus_if.s_cyc_o, 2'b01);
        check("t2_m1_ack", bus_if.m_ack_o, 2'b10);
        step();
        drop(1);
        step();

        // Unmapped read -> internal error, no slave strobed
        req(0, 1'b1, 1'b1, 1'b0, 32'hF000_0000, '0, '0, CTI_CLASSIC);
        step();
        settle();
        check("t3_err", bus_if.m_err_o, 2'b01);
        check("t3_stb", bus_if.s_stb_o, 2'b00);
        check("t3_cyc", bus_if.s_cyc_o, 2'b00);
        check("t3_ack", bus_if.m_ack_o, 2'b00);
        step();
        drop(0);
        settle();
        check("t3_err_clear", bus_if.m_err_o, 2'b00);
        check("t3_no_snoop", snoop_en_o, 1'b0);
        step();

        // Two-beat write burst -> two consecutive snoop pulses
        req(0, 1'b1, 1'b1, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, CTI_INCR);
        step();
        settle();
        check("t4_ack", bus_if.m_ack_o, 2'b01);
        check("t4_sdat", bus_if.s_dat_o[1], 32'hDEAD_BEEF);
        check("t4_snoop_before", snoop_en_o, 1'b0);
        step();
        req(0, 1'b1, 1'b1, 1'b1, 32'h1000_0014, 32'h1234_5678, 4'h3, CTI_EOB);
        settle();
        check("t4_snoop_en0", snoop_en_o, 1'b1);
        check("t4_snoop_adr0", snoop_adr_o, 32'h1000_0010);
        check("t4_snoop_dat0", snoop_dat_o, 32'hDEAD_BEEF);
        check("t4_snoop_sel0", snoop_sel_o, 4'hF);
        step();
        drop(0);
        settle();
        check("t4_snoop_en1", snoop_en_o, 1'b1);
        check("t4_snoop_adr1", snoop_adr_o, 32'h1000_0014);
        check("t4_snoop_dat1", snoop_dat_o, 32'h1234_5678);
        check("t4_snoop_sel1", snoop_sel_o, 4'h3);
        step();
        settle();
        check("t4_snoop_end", snoop_en_o, 1'b0);

        // Bus hold raised during M1 read; M0 kept off until hold released
        req(1, 1'b1, 1'b1, 1'b0, 32'h0000_0080, '0, '0, CTI_CLASSIC);
        step();
        bus_hold_i = 1'b1;
        req(0, 1'b1, 1'b1, 1'b0, 32'h0000_0004, '0, '0, CTI_CLASSIC);
        settle();
        check("t5_hack_busy", bus_hold_ack_o, 1'b0);
        check("t5_m1_ack", bus_if.m_ack_o, 2'b10);
        step();
        drop(1);
        settle();
        check("t5_hack_release", bus_hold_ack_o, 1'b0);
        step();
        settle();
        check("t5_hack_idle", bus_hold_ack_o, 1'b0);
        step();
        settle();
        check("t5_hack", bus_hold_ack_o, 1'b1);
        check("t5_held_scyc", bus_if.s_cyc_o, 2'b00);
        step();
        settle();
        check("t5_hack_still", bus_hold_ack_o, 1'b1);
        check("t5_held_mack", bus_if.m_ack_o, 2'b00);
        bus_hold_i = 1'b0;
        step();
        settle();
        check("t5_unhold_ack", bus_hold_ack_o, 1'b0);
        check("t5_unhold_scyc", bus_if.s_cyc_o, 2'b00);
        step();
        settle();
        check("t5_m0_scyc", bus_if.s_cyc_o, 2'b01);
        check("t5_m0_ack", bus_if.m_ack_o, 2'b01);
        step();
        drop(0);
        step();

        // Silent slave 1
        silent = 2'b10;
        req(0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, '0, '0, CTI_CLASSIC);
        step();
`ifdef SOC_B3_WB_TIMEOUT_EN
        for (int c = 1; c <= TMO; c++) begin
            settle();
            check("t6_tmo_err", bus_if.m_err_o, (c == TMO) ? 2'b01 : 2'b00);
            check("t6_tmo_scyc", bus_if.s_cyc_o, 2'b10);
            step();
        end
        settle();
        check("t6_tmo_scyc_drop", bus_if.s_cyc_o, 2'b00);
        check("t6_tmo_err_once", bus_if.m_err_o, 2'b00);
`else
        for (int c = 1; c <= TMO + 4; c++) begin
            settle();
            check("t6_stall_err", bus_if.m_err_o, 2'b00);
            check("t6_stall_stb", bus_if.s_stb_o, 2'b10);
            step();
        end
`endif
        drop(0);
        silent = '0;
        step();
        step();
        settle();
        check("t6_end_scyc", bus_if.s_cyc_o, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
